// File: rtl/audio_sample_feeder.sv
// Bus-fed sample FIFO that prefills to START_LEVEL and then streams to a valid/ready sink.
// Define AUDIO_FEEDER_UNDERRUN_CNT_EN to add a 16-bit saturating underrun counter at address 2.
module audio_sample_feeder #(
  parameter int DATA_SIZE   = 28,
  parameter int DEPTH       = 1024,
  parameter int START_LEVEL = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 chipselect,
  input  logic [1:0]           address,
  input  logic                 write,
  input  logic [31:0]          writedata,
  input  logic                 read,
  output logic [31:0]          readdata,
  output logic                 sink_valid,
  output logic [DATA_SIZE-1:0] sink_data,
  input  logic                 sink_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] START_L = (AW+1)'(START_LEVEL);
  localparam logic [AW:0] LVL_ONE = (AW+1)'(1);
  localparam logic [AW:0] LVL_ZERO = (AW+1)'(0);

  typedef enum logic [0:0] {FILL = 1'b0, RUN = 1'b1} state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [DATA_SIZE-1:0]   mem_r [DEPTH];
  logic [AW-1:0]          wr_ptr_r;
  logic [AW-1:0]          rd_ptr_r;
  logic [AW:0]            mem_cnt_r;
  logic                   out_full_r;
  logic [DATA_SIZE-1:0]   out_data_r;
  logic                   ovf_r;
  logic [AW:0]            level_s;
  logic                   bus_push_s;
  logic                   push_s;
  logic                   ovf_set_s;
  logic                   clr_s;
  logic                   transfer_s;
  logic                   load_s;
  logic                   underrun_s;
  logic [31:0]            status_s;
  logic [31:0]            urun_rd_s;
  logic                   unused_s;

  assign unused_s   = ^writedata[31:DATA_SIZE];
  assign level_s    = mem_cnt_r + {{AW{1'b0}}, out_full_r};
  assign bus_push_s = chipselect && write && (address == 2'd0);
  assign push_s     = bus_push_s && (level_s < DEPTH_L);
  assign ovf_set_s  = bus_push_s && (level_s == DEPTH_L);
  assign clr_s      = chipselect && write && (address == 2'd1) && writedata[0];
  assign sink_valid = (state_r == RUN) && out_full_r;
  assign sink_data  = out_data_r;
  assign transfer_s = sink_valid && sink_ready;
  // The output register reloads whenever it is empty or being consumed this cycle.
  assign load_s     = (!out_full_r || transfer_s) && (mem_cnt_r != LVL_ZERO);
  assign underrun_s = (state_r == RUN) && transfer_s && (level_s == LVL_ONE) && !push_s;

  // Next-state logic for the prefill/stream controller.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FILL: begin
        if (level_s >= START_L) state_next_s = RUN;
        else                    state_next_s = FILL;
      end
      RUN: begin
        if (underrun_s) state_next_s = FILL;
        else            state_next_s = RUN;
      end
      default: state_next_s = FILL;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= FILL;
    else     state_r <= state_next_s;
  end

  // Sample storage; no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (push_s && !rst) mem_r[wr_ptr_r] <= writedata[DATA_SIZE-1:0];
  end

  // Pointers, storage occupancy and the fall-through output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      mem_cnt_r  <= LVL_ZERO;
      out_full_r <= 1'b0;
      out_data_r <= {DATA_SIZE{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      if (load_s) begin
        rd_ptr_r   <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
        out_data_r <= mem_r[rd_ptr_r];
        out_full_r <= 1'b1;
      end else if (transfer_s) begin
        out_full_r <= 1'b0;
      end
      mem_cnt_r <= mem_cnt_r + (AW+1)'(push_s) - (AW+1)'(load_s);
    end
  end

  // Sticky overflow flag; a same-cycle overflow wins over the clear.
  always_ff @(posedge clk) begin
    if (rst)            ovf_r <= 1'b0;
    else if (ovf_set_s) ovf_r <= 1'b1;
    else if (clr_s)     ovf_r <= 1'b0;
  end

`ifdef AUDIO_FEEDER_UNDERRUN_CNT_EN
  logic [15:0] urun_cnt_r;

  // Saturating underrun counter; a same-cycle underrun wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      urun_cnt_r <= 16'd0;
    end else if (underrun_s) begin
      if (urun_cnt_r != 16'hFFFF) urun_cnt_r <= urun_cnt_r + 16'd1;
    end else if (clr_s) begin
      urun_cnt_r <= 16'd0;
    end
  end

  assign urun_rd_s = {16'd0, urun_cnt_r};
`else
  assign urun_rd_s = 32'd0;
`endif

  // Status word: overflow, streaming flag and current fill level.
  always_comb begin
    status_s         = 32'd0;
    status_s[31]     = ovf_r;
    status_s[30]     = (state_r == RUN);
    status_s[AW:0]   = level_s;
  end

  // Registered bus read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      readdata <= 32'd0;
    end else if (chipselect && read) begin
      case (address)
        2'd0:    readdata <= 32'd0;
        2'd1:    readdata <= status_s;
        2'd2:    readdata <= urun_rd_s;
        default: readdata <= 32'd0;
      endcase
    end
  end

endmodule
